// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that turns an external single-port 8x8 RAM into a byte FIFO.
// A registered output slot sits after the RAM, giving one extra entry of capacity.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   ramCnt_q, ramCnt_d;
    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              prioRd_q, prioRd_d;

    logic              fillReq;
    logic              doWrite;
    logic              doRead;

    // The single RAM port serves either a write or an output-slot refill each
    // cycle; prioRd_q makes the two take turns when both want the port.
    always_comb begin
        fillReq  = (ramCnt_q != '0) && (!outValid_q || out_ready);
        in_ready = !rst && (ramCnt_q != FULL_CNT) && !(fillReq && prioRd_q);
        doWrite  = in_valid && in_ready;
        doRead   = fillReq && !doWrite;
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        ramCnt_d   = ramCnt_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        prioRd_d   = prioRd_q;

        if (doWrite) begin
            wrPtr_d  = wrPtr_q + 1'b1;
            ramCnt_d = ramCnt_q + 1'b1;
            prioRd_d = 1'b1;
        end else if (doRead) begin
            rdPtr_d    = rdPtr_q + 1'b1;
            ramCnt_d   = ramCnt_q - 1'b1;
            outData_d  = ram_rdata;
            outValid_d = 1'b1;
            prioRd_d   = 1'b0;
        end

        // A consumed slot that is not refilled this cycle simply empties.
        if (outValid_q && out_ready && !doRead) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            ramCnt_q   <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            prioRd_q   <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            ramCnt_q   <= ramCnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            prioRd_q   <= prioRd_d;
        end
    end

    assign ram_addr  = doWrite ? wrPtr_q : rdPtr_q;
    assign ram_we    = doWrite;
    assign ram_wdata = in_data;

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign count     = ramCnt_q + {{ADDR_W{1'b0}}, outValid_q};
    assign full      = (ramCnt_q == FULL_CNT);
    assign empty     = (count == '0);

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Single-port FIFO controller that sits directly upstream of the 8x8 RAM and drives its clk, addr, we and data_in pins.
- Consumes the RAM's combinational data_out.
- Turns the RAM into an 8-entry byte FIFO with one extra registered output slot (total capacity 9).
- Producer side uses a valid/ready handshake; consumer side uses a valid/ready handshake.

Parameters:
- DATA_W, 8, data width; must match the RAM word width.
- ADDR_W, 3, RAM address width; RAM depth = 2**ADDR_W = 8.

Ports:
- clk  input  1  system clock, rising edge; also wired to the RAM clk.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  producer data.
- in_valid  input  1  producer data valid.
- in_ready  output  1  controller accepts in_data this cycle.
- out_data  output  DATA_W  registered head-of-FIFO data.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer takes out_data this cycle.
- ram_addr  output  ADDR_W  RAM addr.
- ram_we  output  1  RAM we.
- ram_wdata  output  DATA_W  RAM data_in.
- ram_rdata  input  DATA_W  RAM data_out (combinational read of ram_addr).
- count  output  ADDR_W+1  total entries held (RAM plus output register), 0..9.
- full  output  1  RAM occupancy == 8.
- empty  output  1  count == 0.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- State: wr_ptr, rd_ptr (ADDR_W bits, wrap 7->0); ram_cnt (0..8); out_valid; out_data; prio_rd (last-op bit).
- Reset values: wr_ptr=0, rd_ptr=0, ram_cnt=0, out_valid=0, out_data=0, prio_rd=0. Hence count=0, empty=1, full=0.
- ram_we is forced to 0 during any cycle with rst=1. RAM contents are not cleared and are don't-care.
- One RAM operation per cycle (single port), chosen combinationally:
  - fill_req = (ram_cnt!=0) && (!out_valid || out_ready)
  - in_ready = !rst && (ram_cnt!=8) && !(fill_req && prio_rd)
  - do_write = in_valid && in_ready
  - do_read = fill_req && !do_write
- in_ready never depends on in_valid. It may depend combinationally on out_ready.
- Arbitration: prio_rd<=1 after a do_write cycle and prio_rd<=0 after a do_read cycle; otherwise hold. Under contention, writes and reads therefore alternate.
- RAM drive:
  - ram_addr = do_write ? wr_ptr : rd_ptr
  - ram_we = do_write
  - ram_wdata = in_data
- do_write: wr_ptr<=wr_ptr+1 (mod 8); ram_cnt increments.
- do_read: out_data<=ram_rdata; out_valid<=1; rd_ptr<=rd_ptr+1; ram_cnt decrements.
- Same-cycle write and read never occur, so ram_cnt changes by at most 1 per cycle.
- Output slot:
  - If out_valid && out_ready && !do_read: out_valid<=0 and out_data holds its value.
  - If out_valid && !out_ready: out_data and out_valid hold stable.
- Status outputs: count = ram_cnt + out_valid; full = (ram_cnt==8); empty = (count==0).
- Latency: an entry accepted into an empty FIFO in cycle N is read in cycle N+1 and shows out_valid=1 in cycle N+2.
- Throughput: one entry per cycle when only writing or only draining. One per 2 cycles for sustained simultaneous push and pop.
- Ordering: strict FIFO order, including across pointer wrap-around.
- No overflow or underflow is possible. Writes are blocked when full; reads require ram_cnt!=0.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight entries are discarded. No ram_we pulse occurs in the reset cycle.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0, ram_we=0, out_valid=0, count=0, empty=1, full=0.
- Single push 0xA5 into empty FIFO, out_ready=0:
  - cycle 0: ram_we=1, ram_addr=0
  - cycle 1: ram_we=0, ram_addr=0 (read)
  - cycle 2: out_valid=1, out_data=0xA5, count=1
- Fill with out_ready=0, pushing 0x10..0x19 back-to-back:
  - exactly 9 accepted (0x10 lands in the output register); count=9, full=1, in_ready=0, 0x19 stalls.
  - then out_ready=1: drains 0x10..0x18 in order; 0x19 then accepted.
- Wrap-around: in_valid=1 and out_ready=1 continuously for 20 values 0x00..0x13 -> output order identical, ram_we alternates, wr_ptr/rd_ptr wrap 7->0 at least twice, no loss.
- Output backpressure: with 3 entries held, toggle out_ready 1,0,0,1 -> out_data stable while out_valid && !out_ready; exactly one entry consumed per out_ready=1 cycle.
- Reset mid-stream at count=5 -> next cycle count=0, empty=1, out_valid=0. A subsequent push of 0x3C appears at out_data 2 cycles later, from ram_addr=0.
